// File: rtl/inport_vc_buf_pkg.sv
// Shared encodings for the input-port VC buffer: packet FSM states and flit-type tags.
package inport_vc_buf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } pkt_state_t;

  // Tag bits are {tail, head}; 11 is a single-flit packet.
  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_t;

  function automatic flit_type_t flit_type(input logic head, input logic tail);
    return flit_type_t'({tail, head});
  endfunction

endpackage

// File: rtl/inport_vc_fifo.sv
// Single virtual-channel circular FIFO with occupancy status, packet-framing FSM and sticky errors.
module inport_vc_fifo
  import inport_vc_buf_pkg::*;
#(
  parameter int flit_w   = 32,
  parameter int buf_size = 8,
  parameter int ptr_w    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [flit_w-1:0] wr_data,
  input  logic              wr_head,
  input  logic              wr_tail,
  input  logic              rd_req,
  output logic [flit_w-1:0] rd_data,
  output logic              rd_head,
  output logic              rd_tail,
  output logic              rd_ok,
  output logic              bypass,
  output logic              empty,
  output logic              full,
  output logic              pre_full,
  output logic              proto_err,
  output logic              ovf_err
);

  localparam int addr_w = (buf_size > 1) ? $clog2(buf_size) : 1;
  localparam logic [ptr_w-1:0] depth = ptr_w'(buf_size);
  localparam logic [ptr_w-1:0] last  = ptr_w'(buf_size - 1);

  logic [flit_w-1:0] data_mem [buf_size];
  logic [1:0]        type_mem [buf_size];

  logic [ptr_w-1:0] rd_ptr, wr_ptr, cnt, cnt_next;
  pkt_state_t       state, state_next;
  logic             wr_ok, store, pop, proto_hit;

  // A same-VC read frees the slot the write needs, so a full FIFO still accepts it.
  always_comb begin
    bypass = wr_req && rd_req && (cnt == '0);
    pop    = rd_req && (cnt != '0);
    rd_ok  = pop || bypass;
    wr_ok  = wr_req && ((cnt != depth) || rd_req);
    store  = wr_ok && !bypass;
    cnt_next = cnt;
    if (store && !pop)
      cnt_next = cnt + 1'b1;
    else if (pop && !store)
      cnt_next = cnt - 1'b1;
  end

  always_comb begin
    state_next = state;
    proto_hit  = 1'b0;
    if (wr_ok) begin
      case (flit_type(wr_head, wr_tail))
        FT_HEAD: begin
          proto_hit  = (state == PKT);
          state_next = PKT;
        end
        FT_TAIL: begin
          proto_hit  = (state == IDLE);
          state_next = IDLE;
        end
        FT_SINGLE: begin
          proto_hit  = (state == PKT);
          state_next = IDLE;
        end
        default: proto_hit = (state == IDLE);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      state     <= IDLE;
      proto_err <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      if (store)
        wr_ptr <= (wr_ptr == last) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == last) ? '0 : rd_ptr + 1'b1;
      cnt   <= cnt_next;
      empty <= (cnt_next == '0);
      full  <= (cnt_next == depth);
      state <= state_next;
      if (proto_hit)
        proto_err <= 1'b1;
      if (wr_req && !wr_ok)
        ovf_err <= 1'b1;
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (store) begin
      data_mem[wr_ptr[addr_w-1:0]] <= wr_data;
      type_mem[wr_ptr[addr_w-1:0]] <= {wr_tail, wr_head};
    end
  end

  assign rd_data  = data_mem[rd_ptr[addr_w-1:0]];
  assign rd_head  = type_mem[rd_ptr[addr_w-1:0]][0];
  assign rd_tail  = type_mem[rd_ptr[addr_w-1:0]][1];
  assign pre_full = (cnt >= last);

endmodule

// File: rtl/inport_vc_buf.sv
// Router input port: per-VC FIFOs, read mux with same-VC bypass, registered output and credit return.
module inport_vc_buf
  import inport_vc_buf_pkg::*;
#(
  parameter int flit_size = 2,
  parameter int phit_size = 16,
  parameter int buf_size  = 8,
  parameter int vc_num    = 4,
  parameter int vc_w      = 2,
  parameter int ptr_w     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [flit_size*phit_size-1:0] indata,
  input  logic                           new_flit,
  input  logic [vc_w-1:0]                in_vc,
  input  logic                           in_head,
  input  logic                           in_tail,
  input  logic                           want,
  input  logic [vc_w-1:0]                rd_vc,
  output logic [flit_size*phit_size-1:0] outdata,
  output logic                           out_valid,
  output logic                           out_head,
  output logic                           out_tail,
  output logic [vc_w-1:0]                out_vc,
  output logic [vc_num-1:0]              empty,
  output logic [vc_num-1:0]              full,
  output logic [vc_num-1:0]              pre_full,
  output logic                           credit_valid,
  output logic [vc_w-1:0]                credit_vc,
  output logic                           proto_err,
  output logic                           ovf_err
);

  localparam int flit_w = flit_size * phit_size;

  logic [vc_num-1:0] wr_req, rd_req, rd_ok, bypass, head_v, tail_v, proto_v, ovf_v;
  logic [flit_w-1:0] data_v [vc_num];

  logic              sel_ok, sel_bypass, sel_head, sel_tail;
  logic [flit_w-1:0] sel_data;

  genvar gi;
  generate
    for (gi = 0; gi < vc_num; gi++) begin : g_vc
      assign wr_req[gi] = new_flit && (in_vc == vc_w'(gi));
      assign rd_req[gi] = want && (rd_vc == vc_w'(gi));

      inport_vc_fifo #(
        .flit_w   (flit_w),
        .buf_size (buf_size),
        .ptr_w    (ptr_w)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req[gi]),
        .wr_data   (indata),
        .wr_head   (in_head),
        .wr_tail   (in_tail),
        .rd_req    (rd_req[gi]),
        .rd_data   (data_v[gi]),
        .rd_head   (head_v[gi]),
        .rd_tail   (tail_v[gi]),
        .rd_ok     (rd_ok[gi]),
        .bypass    (bypass[gi]),
        .empty     (empty[gi]),
        .full      (full[gi]),
        .pre_full  (pre_full[gi]),
        .proto_err (proto_v[gi]),
        .ovf_err   (ovf_v[gi])
      );
    end
  endgenerate

  always_comb begin
    sel_ok     = 1'b0;
    sel_bypass = 1'b0;
    sel_data   = '0;
    sel_head   = 1'b0;
    sel_tail   = 1'b0;
    for (int v = 0; v < vc_num; v++) begin
      if (rd_vc == vc_w'(v)) begin
        sel_ok     = rd_ok[v];
        sel_bypass = bypass[v];
        sel_data   = data_v[v];
        sel_head   = head_v[v];
        sel_tail   = tail_v[v];
      end
    end
  end

  // On a bypass the flit comes straight from the input, never touching storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outdata      <= '0;
      out_valid    <= 1'b0;
      out_head     <= 1'b0;
      out_tail     <= 1'b0;
      out_vc       <= '0;
      credit_valid <= 1'b0;
      credit_vc    <= '0;
    end else begin
      out_valid    <= sel_ok;
      credit_valid <= sel_ok;
      if (sel_ok) begin
        outdata   <= sel_bypass ? indata  : sel_data;
        out_head  <= sel_bypass ? in_head : sel_head;
        out_tail  <= sel_bypass ? in_tail : sel_tail;
        out_vc    <= rd_vc;
        credit_vc <= rd_vc;
      end
    end
  end

  assign proto_err = |proto_v;
  assign ovf_err   = |ovf_v;

endmodule

// File: doc/inport_vc_buf.md
INPORT_VC_BUF -- requirements
Module: inport_vc_buf

Interface
REQ-001 Parameter flit_size, default 2, number of phits per flit.
REQ-002 Parameter phit_size, default 16, phit width in bits.
REQ-003 Parameter buf_size, default 8, flit slots per virtual channel (VC); legal range 2 or more.
REQ-004 Parameter vc_num, default 4, number of VCs; legal range 1 or more.
REQ-005 Parameter vc_w, default 2, VC index width; equals max(1, ceil(log2(vc_num))).
REQ-006 Parameter ptr_w, default 4, occupancy counter and pointer width; equals floor(log2(buf_size))+1.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 indata  input  flit_size*phit_size  incoming flit.
REQ-010 new  input  1  write strobe for indata.
REQ-011 in_vc  input  vc_w  target VC of the write.
REQ-012 in_head / in_tail  input  1 each  flit-type tags of the write.
REQ-013 want  input  1  read request.
REQ-014 rd_vc  input  vc_w  VC to read.
REQ-015 outdata  output  flit_size*phit_size  registered read flit.
REQ-016 out_valid / out_head / out_tail  output  1 each  registered read qualifiers.
REQ-017 out_vc  output  vc_w  VC of the flit on outdata.
REQ-018 empty / full / pre_full  output  vc_num each  per-VC status; bit v refers to VC v.
REQ-019 credit_valid / credit_vc  output  1 / vc_w  registered credit return to the upstream router.
REQ-020 proto_err / ovf_err  output  1 each  sticky error flags.

Function
REQ-021 Each VC is an independent circular FIFO with rd_ptr, wr_ptr and cnt; pointers wrap from buf_size-1 to 0.
REQ-022 Write accepted when new=1 and cnt[in_vc]<buf_size, or under the same-VC simultaneous-read rules in REQ-026/027; otherwise dropped and ovf_err set.
REQ-023 Read accepted when want=1 and cnt[rd_vc]>0; the flit appears on outdata one cycle later with out_valid=1 and out_vc=rd_vc.
REQ-024 Read of an empty VC (no same-VC write): out_valid=0 next cycle; outdata, out_head, out_tail, out_vc hold; no pointer change.
REQ-025 Simultaneous write and read on different VCs: both proceed independently.
REQ-026 Same VC, cnt=0: bypass; next cycle outdata=indata with in_head/in_tail; cnt stays 0.
REQ-027 Same VC, cnt=buf_size: read and write both accepted; cnt unchanged; no overflow.
REQ-028 empty[v]=(cnt[v]==0), full[v]=(cnt[v]==buf_size), both registered; pre_full[v]=(cnt[v]>=buf_size-1), combinational from registered cnt.
REQ-029 credit_valid pulses for exactly one cycle, one cycle after each accepted read (bypass included), with credit_vc=rd_vc.
REQ-030 Per-VC packet FSM with states IDLE and PKT.
REQ-031 IDLE->PKT on accepted write with in_head=1, in_tail=0.
REQ-032 PKT->IDLE on accepted write with in_tail=1.
REQ-033 A head+tail flit leaves the FSM in IDLE.
REQ-034 Body/tail write in IDLE, or head write in PKT, sets proto_err; the flit is still stored.
REQ-035 proto_err and ovf_err stay set until reset.

Reset
REQ-036 On reset, asynchronously: all cnt, rd_ptr and wr_ptr = 0.
REQ-037 On reset: empty=all ones, full=0, pre_full=0.
REQ-038 On reset: outdata=0, out_valid=0, out_head=0, out_tail=0, out_vc=0.
REQ-039 On reset: credit_valid=0, credit_vc=0, all FSMs IDLE, proto_err=0, ovf_err=0.
REQ-040 Flit storage is not cleared on reset.
REQ-041 Reset asserted mid-transfer discards in-flight reads and writes; no credit is issued for them.

Structure
REQ-042 Shared package holds the FSM state encoding (IDLE=0, PKT=1) and the flit-type tag encoding (head=01, tail=10, body=00).
REQ-043 One sub-module, inport_vc_fifo, implements a single-VC FIFO (storage, pointers, cnt, packet FSM) and is instantiated vc_num times via generate.
REQ-044 Top level contains read mux, bypass, output registers and credit logic only.

Verification
REQ-045 Reset, then write 8 flits to VC2 (buf_size=8) -> full[2]=1 after the 8th write, pre_full[2]=1 after the 7th; a 9th write sets ovf_err=1 and cnt stays 8.
REQ-046 Read VC2 eight times -> flits return in order, one cycle after each want; empty[2]=1 after the last read; eight credit pulses with credit_vc=2; read pointer wraps to 0.
REQ-047 Empty VC1, new=1 and want=1 both on VC1 with indata=0xA5A5_0001 -> next cycle outdata=0xA5A5_0001, out_valid=1, credit_valid=1, empty[1] stays 1.
REQ-048 VC0 full, simultaneous write and read on VC0 -> oldest flit output, new flit stored, full[0] stays 1, ovf_err stays 0.
REQ-049 Write body flit to IDLE VC3 -> proto_err=1 and stays 1; a head then a tail flit on VC3 return its FSM to IDLE.
REQ-050 Assert reset mid-read (between clock edges) -> all outputs take their reset values immediately, and no credit pulse follows.
